// File: rtl/ym_bus_writer.sv
// YM register-write bus initiator: queues (chip, port, reg, data) commands in a FIFO and
// replays each as an address-write cycle followed by a data-write cycle on cs/addr/din/wr_n.
module ym_bus_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int ADDR_WAIT  = 102,
    parameter int DATA_WAIT  = 498
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_chip,
    input  logic       cmd_port,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic [5:0] cs,
    output logic [1:0] addr,
    output logic [7:0] din,
    output logic       wr_n,
    output logic       busy
);

    localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_SH = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int MAX_SA = (MAX_SH > ADDR_WAIT) ? MAX_SH : ADDR_WAIT;
    localparam int MAX_P  = (MAX_SA > DATA_WAIT) ? MAX_SA : DATA_WAIT;
    localparam int CNT_W  = $clog2(MAX_P) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 23;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_AWAIT  = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_DWAIT  = CNT_W'(DATA_WAIT - 1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_EMPTY = (PTR_W+1)'(0);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT
    } state_t;

    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     count_r, count_next_s;
    logic               cmd_ready_r, busy_r;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [5:0]         chip_r;
    logic               port_r;
    logic [7:0]         reg_r, data_r;
    logic [5:0]         cs_r;
    logic [1:0]         addr_r;
    logic [7:0]         din_r;
    logic               wr_n_r;

    logic               push_s, pop_s, start_s, fsm_idle_next_s, cnt_done_s;
    logic [5:0]         head_chip_s;
    logic               head_port_s;
    logic [7:0]         head_reg_s, head_data_s;

    assign {head_chip_s, head_port_s, head_reg_s, head_data_s} = mem_r[rd_ptr_r];

    // Handshake, pop decision and the FSM's next-idle prediction feeding the registered busy.
    always_comb begin
        push_s          = cmd_valid & cmd_ready_r;
        cnt_done_s      = (cnt_r == CNT_ZERO);
        pop_s           = 1'b0;
        fsm_idle_next_s = 1'b0;
        if (count_r != CNT_EMPTY) begin
            if (state_r == IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == D_WAIT) && cnt_done_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
        start_s = pop_s && (head_chip_s != 6'd0);
        if (state_r == IDLE) begin
            fsm_idle_next_s = !start_s;
        end else if ((state_r == D_WAIT) && cnt_done_s) begin
            fsm_idle_next_s = !start_s;
        end else begin
            fsm_idle_next_s = 1'b0;
        end
        count_next_s = count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_chip, cmd_port, cmd_reg, cmd_data};
        end
    end

    // FIFO pointers, occupancy and the registered ready/busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            count_r     <= CNT_EMPTY;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_FULL);
            busy_r      <= (count_next_s != CNT_EMPTY) || !fsm_idle_next_s;
        end
    end

    // Bus sequencer: each state loads the shared down-counter on entry and drives registered bus values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            chip_r  <= 6'd0;
            port_r  <= 1'b0;
            reg_r   <= 8'd0;
            data_r  <= 8'd0;
            cs_r    <= 6'd0;
            addr_r  <= 2'd0;
            din_r   <= 8'd0;
            wr_n_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        chip_r  <= head_chip_s;
                        port_r  <= head_port_s;
                        reg_r   <= head_reg_s;
                        data_r  <= head_data_s;
                        cs_r    <= head_chip_s;
                        addr_r  <= {head_port_s, 1'b0};
                        din_r   <= head_reg_s;
                        wr_n_r  <= 1'b1;
                        cnt_r   <= LD_SETUP;
                        state_r <= A_SETUP;
                    end
                end
                A_SETUP: begin
                    if (cnt_done_s) begin
                        wr_n_r  <= 1'b0;
                        cnt_r   <= LD_STROBE;
                        state_r <= A_STROBE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                A_STROBE: begin
                    if (cnt_done_s) begin
                        wr_n_r  <= 1'b1;
                        cnt_r   <= LD_HOLD;
                        state_r <= A_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                A_HOLD: begin
                    if (cnt_done_s) begin
                        cs_r    <= 6'd0;
                        addr_r  <= 2'd0;
                        din_r   <= 8'd0;
                        cnt_r   <= LD_AWAIT;
                        state_r <= A_WAIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                A_WAIT: begin
                    if (cnt_done_s) begin
                        cs_r    <= chip_r;
                        addr_r  <= {port_r, 1'b1};
                        din_r   <= data_r;
                        cnt_r   <= LD_SETUP;
                        state_r <= D_SETUP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                D_SETUP: begin
                    if (cnt_done_s) begin
                        wr_n_r  <= 1'b0;
                        cnt_r   <= LD_STROBE;
                        state_r <= D_STROBE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                D_STROBE: begin
                    if (cnt_done_s) begin
                        wr_n_r  <= 1'b1;
                        cnt_r   <= LD_HOLD;
                        state_r <= D_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                D_HOLD: begin
                    if (cnt_done_s) begin
                        cs_r    <= 6'd0;
                        addr_r  <= 2'd0;
                        din_r   <= 8'd0;
                        cnt_r   <= LD_DWAIT;
                        state_r <= D_WAIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                D_WAIT: begin
                    // Queued work chains straight into the next address setup without an IDLE cycle.
                    if (cnt_done_s) begin
                        if (start_s) begin
                            chip_r  <= head_chip_s;
                            port_r  <= head_port_s;
                            reg_r   <= head_reg_s;
                            data_r  <= head_data_s;
                            cs_r    <= head_chip_s;
                            addr_r  <= {head_port_s, 1'b0};
                            din_r   <= head_reg_s;
                            wr_n_r  <= 1'b1;
                            cnt_r   <= LD_SETUP;
                            state_r <= A_SETUP;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    cs_r    <= 6'd0;
                    addr_r  <= 2'd0;
                    din_r   <= 8'd0;
                    wr_n_r  <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign cs        = cs_r;
    assign addr      = addr_r;
    assign din       = din_r;
    assign wr_n      = wr_n_r;

endmodule

// File: tb/tb_ym_bus_writer.sv
// Directed bench for ym_bus_writer: a negedge bus monitor logs every write strobe and the
// test compares the log against hand-computed cycle numbers and bus values.
module tb_ym_bus_writer;

    localparam int HOLD_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [5:0] cmd_chip = 6'd0;
    logic       cmd_port = 1'b0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [5:0] cs;
    logic [1:0] addr;
    logic [7:0] din;
    logic       wr_n;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    ym_bus_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chip(cmd_chip), .cmd_port(cmd_port), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .cs(cs), .addr(addr), .din(din), .wr_n(wr_n), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [5:0] cs;
        logic [1:0] addr;
        logic [7:0] din;
        int         len;
        int         setup;
    } strobe_t;

    strobe_t sq[$];
    int      stab_err = 0;

    // Strobe logger: records fall cycle, bus values, low length and setup run; flags any bus change under strobe/hold.
    initial begin
        logic        prev_wr_n;
        logic [15:0] prev_bus, cap_bus, cur_bus;
        int          low_len, setup_run, hold_left;
        strobe_t     rec;
        prev_wr_n = 1'b1; prev_bus = 16'd0; cap_bus = 16'd0;
        low_len = 0; setup_run = 0; hold_left = 0;
        forever begin
            @(negedge clk);
            cur_bus = {cs, addr, din};
            if (prev_wr_n === 1'b1 && wr_n === 1'b0) begin
                rec.at = cyc; rec.cs = cs; rec.addr = addr; rec.din = din;
                rec.len = 0; rec.setup = setup_run;
                sq.push_back(rec);
                cap_bus = cur_bus; low_len = 1; hold_left = 0;
            end else if (wr_n === 1'b0) begin
                low_len++;
                if (cur_bus !== cap_bus) stab_err++;
            end else if (prev_wr_n === 1'b0 && wr_n === 1'b1) begin
                if (sq.size() > 0) sq[sq.size()-1].len = low_len;
                if (cs !== 6'd0) begin
                    if (cur_bus !== cap_bus) stab_err++;
                    hold_left = HOLD_CYC - 1;
                end else begin
                    hold_left = 0;
                end
            end else if (hold_left > 0) begin
                if (cur_bus !== cap_bus) stab_err++;
                hold_left--;
            end
            if (wr_n === 1'b1 && cs !== 6'd0 && cs !== 6'bx) begin
                setup_run = (cur_bus === prev_bus) ? setup_run + 1 : 1;
            end else begin
                setup_run = 0;
            end
            prev_wr_n = wr_n;
            prev_bus  = cur_bus;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Presents a command right after a negedge and returns at the negedge following acceptance.
    task automatic push(input logic [5:0] ch, input logic p, input logic [7:0] r, input logic [7:0] d,
                        output int acc);
        logic was_ready;
        int   guard;
        cmd_chip = ch; cmd_port = p; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
        acc = -1; guard = 0;
        while (acc < 0 && guard < 5000) begin
            was_ready = cmd_ready;
            @(negedge clk);
            if (was_ready === 1'b1) acc = cyc;
            guard++;
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL push_timeout actual=blocked expected=accepted");
        end
    endtask

    task automatic wait_idle(input int budget, output int fall_at);
        int n;
        n = 0;
        fall_at = -1;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy === 1'b0) begin
            fall_at = cyc;
        end else begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    typedef struct {
        logic [5:0] chip;
        logic       port;
        logic [7:0] rg;
        logic [7:0] data;
        logic [1:0] exp_a_addr;
        logic [1:0] exp_d_addr;
    } vec_t;

    vec_t vecs[4];

    typedef struct {
        logic [5:0] chip;
        logic       port;
        logic [7:0] rg;
        logic [7:0] data;
    } cmd_t;

    cmd_t bp[18];

    initial begin
        int acc, acc0, acc_b, fall, n0, nrec;

        vecs[0] = '{6'd3,  1'b0, 8'h28, 8'hF0, 2'd0, 2'd1};
        vecs[1] = '{6'd1,  1'b1, 8'hB4, 8'hC0, 2'd2, 2'd3};
        vecs[2] = '{6'd5,  1'b1, 8'h00, 8'hFF, 2'd2, 2'd3};
        vecs[3] = '{6'd63, 1'b0, 8'hA5, 8'h5A, 2'd0, 2'd1};
        for (int i = 0; i < 18; i++) begin
            bp[i].chip = 6'((i % 7) + 1);
            bp[i].port = 1'(i & 1);
            bp[i].rg   = 8'(8'h10 + 3 * i);
            bp[i].data = 8'(8'hFF - i);
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single commands: strobe timing and encoding from the vector table
        for (int v = 0; v < 4; v++) begin
            n0 = sq.size();
            push(vecs[v].chip, vecs[v].port, vecs[v].rg, vecs[v].data, acc);
            chk("busy_after_accept", busy, 1);
            wait_idle(2000, fall);
            chk("busy_fall_cycle", fall, acc + 617);
            chk("strobe_count", sq.size() - n0, 2);
            if (sq.size() - n0 >= 2) begin
                chk("a_fall_cycle", sq[n0].at, acc + 3);
                chk("a_cs", sq[n0].cs, vecs[v].chip);
                chk("a_addr", sq[n0].addr, vecs[v].exp_a_addr);
                chk("a_din", sq[n0].din, vecs[v].rg);
                chk("a_strobe_len", sq[n0].len, 4);
                chk("a_setup_len", sq[n0].setup, 2);
                chk("d_fall_cycle", sq[n0+1].at, acc + 113);
                chk("d_cs", sq[n0+1].cs, vecs[v].chip);
                chk("d_addr", sq[n0+1].addr, vecs[v].exp_d_addr);
                chk("d_din", sq[n0+1].din, vecs[v].data);
                chk("d_strobe_len", sq[n0+1].len, 4);
                chk("d_setup_len", sq[n0+1].setup, 2);
            end
        end

        // Backpressure: 1 in flight + 16 queued, then an 18th push blocked until the D_WAIT exit pop
        n0 = sq.size();
        push(bp[0].chip, bp[0].port, bp[0].rg, bp[0].data, acc0);
        for (int i = 1; i < 17; i++) begin
            push(bp[i].chip, bp[i].port, bp[i].rg, bp[i].data, acc);
            chk("bp_accept_cycle", acc, acc0 + i);
        end
        chk("bp_ready_low_full", cmd_ready, 0);
        push(bp[17].chip, bp[17].port, bp[17].rg, bp[17].data, acc_b);
        chk("bp_blocked_push_cycle", acc_b, acc0 + 618);
        chk("bp_ready_low_refill", cmd_ready, 0);
        wait_idle(20000, fall);
        chk("bp_strobe_count", sq.size() - n0, 36);
        if (sq.size() - n0 >= 36) begin
            for (int i = 0; i < 18; i++) begin
                chk("bp_a_fall_cycle", sq[n0+2*i].at, acc0 + 3 + 616 * i);
                chk("bp_a_cs", sq[n0+2*i].cs, bp[i].chip);
                chk("bp_a_addr", sq[n0+2*i].addr, {bp[i].port, 1'b0});
                chk("bp_a_din", sq[n0+2*i].din, bp[i].rg);
                chk("bp_d_addr", sq[n0+2*i+1].addr, {bp[i].port, 1'b1});
                chk("bp_d_din", sq[n0+2*i+1].din, bp[i].data);
            end
        end

        // Chip-0 discard followed by a real command
        n0 = sq.size();
        push(6'd0, 1'b0, 8'h22, 8'h08, acc0);
        push(6'd2, 1'b0, 8'h22, 8'h08, acc_b);
        chk("c0_second_accept", acc_b, acc0 + 1);
        chk("c0_no_bus_cs", cs, 0);
        chk("c0_no_bus_wr_n", wr_n, 1);
        wait_idle(2000, fall);
        chk("c0_busy_fall", fall, acc0 + 618);
        chk("c0_strobe_count", sq.size() - n0, 2);
        if (sq.size() - n0 >= 2) begin
            chk("c0_a_fall_cycle", sq[n0].at, acc0 + 4);
            chk("c0_a_cs", sq[n0].cs, 2);
            chk("c0_a_din", sq[n0].din, 8'h22);
            chk("c0_d_addr", sq[n0+1].addr, 1);
            chk("c0_d_din", sq[n0+1].din, 8'h08);
        end

        // Reset during the first command's data strobe with 5 more queued
        push(6'd4, 1'b0, 8'h30, 8'h11, acc0);
        for (int i = 0; i < 5; i++) push(6'd4, 1'b1, 8'(8'h40 + i), 8'(8'h50 + i), acc);
        while (cyc < acc0 + 114) @(negedge clk);
        chk("mid_dstrobe_wr_n", wr_n, 0);
        chk("mid_dstrobe_addr", addr, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_n", wr_n, 1);
        chk("rst_mid_cs", cs, 0);
        chk("rst_mid_addr", addr, 0);
        chk("rst_mid_din", din, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        nrec = sq.size();
        repeat (1500) @(negedge clk);
        chk("post_rst_no_strobes", sq.size(), nrec);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cs", cs, 0);

        chk("bus_stable_under_strobe_hold", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
